// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
// Holds the FSM state encoding, default bus widths and port-select codes.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_DM = 2'd2
    } arb_state_t;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_DM = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port and backing-memory signals around the arbiter.
// Handshake: a requester raises *_req_i with stable operands and holds it until it sees
// *_ack_o (a one-cycle pulse carrying *_rdata_o); memory sees a one-cycle mem_req_o with
// operands held until the transaction ends, and answers with a one-cycle mem_rvalid_i.
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();

    logic              if_req_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic [DATA_W-1:0] if_rdata_o;
    logic              if_ack_o;
    logic              if_stall_o;

    logic              dm_req_i;
    logic              dm_we_i;
    logic [ADDR_W-1:0] dm_addr_i;
    logic [DATA_W-1:0] dm_wdata_i;
    logic [DATA_W-1:0] dm_rdata_o;
    logic              dm_ack_o;
    logic              dm_stall_o;

    logic              mem_req_o;
    logic              mem_we_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              mem_rvalid_i;
    logic [DATA_W-1:0] mem_rdata_i;

    logic              err_o;

    modport slave (
        input  if_req_i, if_addr_i,
        output if_rdata_o, if_ack_o, if_stall_o,
        input  dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
        output dm_rdata_o, dm_ack_o, dm_stall_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_rvalid_i, mem_rdata_i,
        output err_o
    );

    modport master (
        output if_req_i, if_addr_i,
        input  if_rdata_o, if_ack_o, if_stall_o,
        output dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
        input  dm_rdata_o, dm_ack_o, dm_stall_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_rvalid_i, mem_rdata_i,
        input  err_o
    );

endinterface

// File: rtl/mem_arb_timer.sv
// Response watchdog: counts busy cycles, held at zero while cleared, and flags
// expiry while the count sits at TIMEOUT.
module mem_arb_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (count_q != CW'(TIMEOUT)) begin
            count_q <= count_q + CW'(1);
        end
    end

    assign expired = (count_q == CW'(TIMEOUT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one unified memory between the IF and MEM stages, one transaction at a time,
// with data priority limited by a fetch anti-starvation streak and a response timeout.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W        = DEF_ADDR_W,
    parameter int DATA_W        = DEF_DATA_W,
    parameter int MAX_DM_STREAK = 4,
    parameter int TIMEOUT       = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    mem_port_arbiter_if.slave bus,
    output arb_state_t        dbg_state
);

    localparam int SW = $clog2(MAX_DM_STREAK + 1);

    arb_state_t        state_q;
    logic [SW-1:0]     streak_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              if_ack_q;
    logic              dm_ack_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic [DATA_W-1:0] dm_rdata_q;
    logic              err_q;

    logic if_cand;
    logic dm_cand;
    logic streak_full;
    logic dm_wins;
    logic if_wins;
    logic busy_port;
    logic timer_expired;

    // A port being acknowledged this cycle is still holding its old request.
    assign if_cand     = bus.if_req_i & ~if_ack_q;
    assign dm_cand     = bus.dm_req_i & ~dm_ack_q;
    assign streak_full = (streak_q == SW'(MAX_DM_STREAK));
    assign dm_wins     = dm_cand & ~(if_cand & streak_full);
    assign if_wins     = if_cand & ~dm_wins;
    assign busy_port   = (state_q == BUSY_DM) ? PORT_DM : PORT_IF;

    mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clear   (state_q == IDLE),
        .expired (timer_expired)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            streak_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            if_rdata_q  <= '0;
            dm_rdata_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            mem_req_q <= 1'b0;
            if_ack_q  <= 1'b0;
            dm_ack_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (dm_wins) begin
                        state_q     <= BUSY_DM;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= bus.dm_we_i;
                        mem_addr_q  <= bus.dm_addr_i;
                        mem_wdata_q <= bus.dm_wdata_i;
                        if (!bus.if_req_i) begin
                            streak_q <= '0;
                        end else if (!streak_full) begin
                            streak_q <= streak_q + SW'(1);
                        end
                    end else if (if_wins) begin
                        state_q     <= BUSY_IF;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= bus.if_addr_i;
                        mem_wdata_q <= '0;
                        streak_q    <= '0;
                    end
                end
                BUSY_IF, BUSY_DM: begin
                    // A response in the expiry cycle still counts as a normal completion.
                    if (bus.mem_rvalid_i) begin
                        state_q <= IDLE;
                        if (busy_port == PORT_DM) begin
                            dm_ack_q <= 1'b1;
                            if (!mem_we_q) dm_rdata_q <= bus.mem_rdata_i;
                        end else begin
                            if_ack_q   <= 1'b1;
                            if_rdata_q <= bus.mem_rdata_i;
                        end
                    end else if (timer_expired) begin
                        state_q <= IDLE;
                        err_q   <= 1'b1;
                        if (busy_port == PORT_DM) begin
                            dm_ack_q   <= 1'b1;
                            dm_rdata_q <= '0;
                        end else begin
                            if_ack_q   <= 1'b1;
                            if_rdata_q <= '0;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.if_rdata_o  = if_rdata_q;
    assign bus.if_ack_o    = if_ack_q;
    assign bus.if_stall_o  = bus.if_req_i & ~if_ack_q;
    assign bus.dm_rdata_o  = dm_rdata_q;
    assign bus.dm_ack_o    = dm_ack_q;
    assign bus.dm_stall_o  = bus.dm_req_i & ~dm_ack_q;
    assign bus.mem_req_o   = mem_req_q;
    assign bus.mem_we_o    = mem_we_q;
    assign bus.mem_addr_o  = mem_addr_q;
    assign bus.mem_wdata_o = mem_wdata_q;
    assign bus.err_o       = err_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: a transaction-level model predicts grants,
// memory strobes and acks into queues that a separate monitor consumes.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXS = 2;
    localparam int TMO  = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
    arb_state_t dbg_state;

    mem_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MAX_DM_STREAK(MAXS), .TIMEOUT(TMO)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // {cycle[96:65], we[64], addr[63:32], wdata[31:0]} and {cycle[63:32], rdata[31:0]}
    logic [96:0] mem_q[$];
    logic [63:0] if_q[$];
    logic [63:0] dm_q[$];

    int          mem_log_cyc[$];
    logic [31:0] mem_log_addr[$];
    int          last_if_ack_cyc, last_dm_ack_cyc, dm_ack_cnt;
    logic [31:0] last_if_rdata, last_dm_rdata;

    // Requesters
    bit          if_pend, dm_pend, dm_w;
    logic [31:0] if_a, dm_a, dm_d;
    int          if_burst, dm_burst;
    int          if_rate, dm_rate, drop_rate, spur_rate, never_rate;
    int          fix_delay;
    bit          use_fix_rdata, force_spur;
    logic [31:0] fix_rdata;

    // Transaction-level reference model (state during the current cycle)
    bit          m_busy, m_port, m_we, m_if_ack, m_dm_ack, m_err;
    int          m_age, m_delay, m_streak, step_cyc;
    logic [31:0] m_addr, m_wdata, m_rdata, m_dm_last;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic issue_if(input logic [31:0] a);
        if_pend = 1'b1;
        if_a    = a;
    endtask

    task automatic issue_dm(input bit we, input logic [31:0] a, input logic [31:0] d);
        dm_pend = 1'b1;
        dm_w    = we;
        dm_a    = a;
        dm_d    = d;
    endtask

    // Monitor: consumes expectations whenever the DUT presents a strobe or ack.
    initial begin
        logic [96:0] me;
        logic [63:0] ae;
        forever begin
            @(posedge clk);
            #1;
            if (bus.mem_req_o) begin
                mem_log_cyc.push_back(cyc);
                mem_log_addr.push_back(bus.mem_addr_o);
                if (mem_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL mem_req_unexpected: got 1 expected 0 at cycle %0d", cyc);
                end else begin
                    me = mem_q.pop_front();
                    chk("mem_req_cycle", cyc, me[96:65]);
                    chk("mem_we", bus.mem_we_o, me[64]);
                    chk("mem_addr", bus.mem_addr_o, me[63:32]);
                    chk("mem_wdata", bus.mem_wdata_o, me[31:0]);
                end
            end else if (mem_q.size() > 0 && int'(mem_q[0][96:65]) <= cyc) begin
                me = mem_q.pop_front();
                checks++; errors++;
                $display("FAIL mem_req_missing: got 0 expected 1 at cycle %0d", cyc);
            end
            if (bus.if_ack_o) begin
                last_if_ack_cyc = cyc;
                last_if_rdata   = bus.if_rdata_o;
                if (if_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL if_ack_unexpected: got 1 expected 0 at cycle %0d", cyc);
                end else begin
                    ae = if_q.pop_front();
                    chk("if_ack_cycle", cyc, ae[63:32]);
                    chk("if_rdata", bus.if_rdata_o, ae[31:0]);
                end
            end else if (if_q.size() > 0 && int'(if_q[0][63:32]) <= cyc) begin
                ae = if_q.pop_front();
                checks++; errors++;
                $display("FAIL if_ack_missing: got 0 expected 1 at cycle %0d", cyc);
            end
            if (bus.dm_ack_o) begin
                last_dm_ack_cyc = cyc;
                last_dm_rdata   = bus.dm_rdata_o;
                dm_ack_cnt++;
                if (dm_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL dm_ack_unexpected: got 1 expected 0 at cycle %0d", cyc);
                end else begin
                    ae = dm_q.pop_front();
                    chk("dm_ack_cycle", cyc, ae[63:32]);
                    chk("dm_rdata", bus.dm_rdata_o, ae[31:0]);
                end
            end else if (dm_q.size() > 0 && int'(dm_q[0][63:32]) <= cyc) begin
                ae = dm_q.pop_front();
                checks++; errors++;
                $display("FAIL dm_ack_missing: got 0 expected 1 at cycle %0d", cyc);
            end
        end
    end

    // One clock cycle: drive requesters and memory, check live outputs, advance the model.
    task automatic step();
        bit          rv, ic, dc, grant, done, n_if_ack, n_dm_ack;
        logic [31:0] ack_data;
        arb_state_t  exp_state;
        @(negedge clk);
        step_cyc = cyc;
        if (!if_pend && if_burst > 0) begin
            issue_if($urandom & 32'hFFFF_FFFC);
            if_burst--;
        end else if (!if_pend && $urandom_range(0, 99) < if_rate) begin
            issue_if($urandom & 32'hFFFF_FFFC);
        end
        if (!dm_pend && dm_burst > 0) begin
            issue_dm(1'b1, $urandom & 32'hFFFF_FFFC, $urandom);
            dm_burst--;
        end else if (!dm_pend && $urandom_range(0, 99) < dm_rate) begin
            issue_dm($urandom_range(0, 1) == 1, $urandom & 32'hFFFF_FFFC, $urandom);
        end
        if (if_pend && !m_if_ack && $urandom_range(0, 99) < drop_rate) if_pend = 1'b0;
        if (dm_pend && !m_dm_ack && $urandom_range(0, 99) < drop_rate) dm_pend = 1'b0;

        rv = m_busy && (m_age == m_delay);
        if (!m_busy && (force_spur || $urandom_range(0, 99) < spur_rate)) rv = 1'b1;
        bus.if_req_i     = if_pend;
        bus.if_addr_i    = if_a;
        bus.dm_req_i     = dm_pend;
        bus.dm_we_i      = dm_w;
        bus.dm_addr_i    = dm_a;
        bus.dm_wdata_i   = dm_d;
        bus.mem_rvalid_i = rv;
        bus.mem_rdata_i  = m_busy ? m_rdata : $urandom;
        #1;
        chk("if_stall", bus.if_stall_o, if_pend && !m_if_ack);
        chk("dm_stall", bus.dm_stall_o, dm_pend && !m_dm_ack);
        chk("err_o", bus.err_o, m_err);
        exp_state = !m_busy ? IDLE : (m_port ? BUSY_DM : BUSY_IF);
        chk("dbg_state", dbg_state, exp_state);
        if (m_busy) begin
            chk("mem_addr_hold", bus.mem_addr_o, m_addr);
            chk("mem_we_hold", bus.mem_we_o, m_we);
            chk("mem_wdata_hold", bus.mem_wdata_o, m_wdata);
        end

        n_if_ack = 1'b0;
        n_dm_ack = 1'b0;
        if (!m_busy) begin
            ic    = if_pend && !m_if_ack;
            dc    = dm_pend && !m_dm_ack;
            grant = 1'b0;
            if (dc && !(ic && m_streak == MAXS)) begin
                m_port = 1'b1; m_we = dm_w; m_addr = dm_a; m_wdata = dm_d;
                m_streak = if_pend ? ((m_streak < MAXS) ? m_streak + 1 : MAXS) : 0;
                grant = 1'b1;
            end else if (ic) begin
                m_port = 1'b0; m_we = 1'b0; m_addr = if_a; m_wdata = 32'h0;
                m_streak = 0;
                grant = 1'b1;
            end
            if (grant) begin
                m_busy  = 1'b1;
                m_age   = 0;
                m_delay = (fix_delay >= 0) ? fix_delay :
                          (($urandom_range(0, 99) < never_rate) ? 100 : $urandom_range(0, 5));
                m_rdata = use_fix_rdata ? fix_rdata : $urandom;
                mem_q.push_back({32'(step_cyc + 1), m_we, m_addr, m_wdata});
            end
        end else begin
            done     = 1'b0;
            ack_data = 32'h0;
            if (rv) begin
                done     = 1'b1;
                ack_data = (m_port && m_we) ? m_dm_last : m_rdata;
            end else if (m_age == TMO) begin
                done  = 1'b1;
                m_err = 1'b1;
            end else begin
                m_age++;
            end
            if (done) begin
                m_busy = 1'b0;
                if (m_port) begin
                    n_dm_ack  = 1'b1;
                    m_dm_last = ack_data;
                    dm_q.push_back({32'(step_cyc + 1), ack_data});
                end else begin
                    n_if_ack = 1'b1;
                    if_q.push_back({32'(step_cyc + 1), ack_data});
                end
            end
        end
        if (m_if_ack) if_pend = 1'b0;
        if (m_dm_ack) dm_pend = 1'b0;
        m_if_ack = n_if_ack;
        m_dm_ack = n_dm_ack;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        if_pend = 1'b0;
        dm_pend = 1'b0;
        bus.if_req_i     = 1'b0;
        bus.dm_req_i     = 1'b0;
        bus.mem_rvalid_i = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_if_ack", bus.if_ack_o, 1'b0);
        chk("rst_dm_ack", bus.dm_ack_o, 1'b0);
        chk("rst_if_rdata", bus.if_rdata_o, 32'h0);
        chk("rst_dm_rdata", bus.dm_rdata_o, 32'h0);
        chk("rst_mem_req", bus.mem_req_o, 1'b0);
        chk("rst_mem_we", bus.mem_we_o, 1'b0);
        chk("rst_mem_addr", bus.mem_addr_o, 32'h0);
        chk("rst_mem_wdata", bus.mem_wdata_o, 32'h0);
        chk("rst_err", bus.err_o, 1'b0);
        chk("rst_stalls", {bus.if_stall_o, bus.dm_stall_o}, 2'b00);
        chk("rst_state", dbg_state, IDLE);
        m_busy = 1'b0; m_if_ack = 1'b0; m_dm_ack = 1'b0; m_err = 1'b0;
        m_streak = 0; m_dm_last = 32'h0;
        mem_q.delete(); if_q.delete(); dm_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_quiet();
        if_rate = 0; dm_rate = 0; drop_rate = 0; spur_rate = 0; never_rate = 0;
        if_burst = 0; dm_burst = 0; fix_delay = -1; use_fix_rdata = 1'b0; force_spur = 1'b0;
    endtask

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: got no finish expected finish by time 1000000");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        int t0, n0;
        bus.if_req_i = 1'b0; bus.if_addr_i = '0; bus.dm_req_i = 1'b0; bus.dm_we_i = 1'b0;
        bus.dm_addr_i = '0; bus.dm_wdata_i = '0; bus.mem_rvalid_i = 1'b0; bus.mem_rdata_i = '0;
        if_a = '0; dm_a = '0; dm_d = '0; dm_w = 1'b0; fix_rdata = '0;
        set_quiet();
        reset_dut();

        // Single fetch, memory answers in the second busy cycle
        fix_delay = 1; use_fix_rdata = 1'b1; fix_rdata = 32'h00A0_0093;
        mem_log_cyc.delete(); mem_log_addr.delete();
        issue_if(32'h10);
        step();
        t0 = step_cyc;
        repeat (6) step();
        chk("t1_mem_req_cycle", (mem_log_cyc.size() > 0) ? mem_log_cyc[0] - t0 : -1, 1);
        chk("t1_mem_addr", (mem_log_addr.size() > 0) ? mem_log_addr[0] : 32'hX, 32'h10);
        chk("t1_ack_latency", last_if_ack_cyc - t0, 3);
        chk("t1_if_rdata", last_if_rdata, 32'h00A0_0093);

        // Simultaneous fetch and load: data first, fetch granted in the dm ack cycle
        fix_rdata = 32'hCAFE_0040;
        mem_log_cyc.delete(); mem_log_addr.delete();
        issue_if(32'h20);
        issue_dm(1'b0, 32'h40, 32'h0);
        step();
        t0 = step_cyc;
        repeat (10) step();
        chk("t2_first_addr", (mem_log_addr.size() > 0) ? mem_log_addr[0] : 32'hX, 32'h40);
        chk("t2_second_addr", (mem_log_addr.size() > 1) ? mem_log_addr[1] : 32'hX, 32'h20);
        chk("t2_dm_ack_latency", last_dm_ack_cyc - t0, 3);
        chk("t2_if_mem_req_cycle", (mem_log_cyc.size() > 1) ? mem_log_cyc[1] - t0 : -1, 4);

        // Store answered in its first busy cycle leaves dm_rdata untouched
        fix_delay = 0; fix_rdata = 32'hDEAD_BEEF;
        issue_dm(1'b1, 32'h80, 32'h1234_5678);
        repeat (5) step();
        chk("t6_store_rdata_hold", last_dm_rdata, 32'hCAFE_0040);

        // Back-to-back stores with fetch pressure
        set_quiet();
        mem_log_cyc.delete(); mem_log_addr.delete();
        dm_burst = 6; if_burst = 3;
        for (int i = 0; i < 200 && (dm_burst > 0 || if_burst > 0 || if_pend || dm_pend || m_busy); i++) step();
        chk("t3_txn_count", mem_log_addr.size(), 9);

        // Randomized traffic with flushes, spurious responses and occasional timeouts
        if_rate = 30; dm_rate = 30; drop_rate = 3; spur_rate = 5; never_rate = 2;
        repeat (1500) step();
        set_quiet();
        repeat (40) step();

        // Timeout: memory never answers
        reset_dut();
        fix_delay = 100;
        mem_log_cyc.delete(); mem_log_addr.delete();
        n0 = dm_ack_cnt;
        issue_dm(1'b0, 32'h100, 32'h0);
        for (int i = 0; i < 40 && dm_ack_cnt == n0; i++) step();
        chk("to_ack_seen", dm_ack_cnt - n0, 1);
        chk("to_latency", last_dm_ack_cyc - ((mem_log_cyc.size() > 0) ? mem_log_cyc[0] : 0), 17);
        chk("to_rdata", last_dm_rdata, 32'h0);
        chk("to_err", bus.err_o, 1'b1);
        force_spur = 1'b1;
        step();
        force_spur = 1'b0;
        repeat (3) step();
        chk("to_err_sticky", bus.err_o, 1'b1);

        // Reset in the middle of a data transaction
        issue_dm(1'b0, 32'h200, 32'h0);
        for (int i = 0; i < 10 && !(m_busy && m_port); i++) step();
        repeat (3) step();
        chk("mid_busy_dm", dbg_state, BUSY_DM);
        reset_dut();
        force_spur = 1'b1;
        step();
        force_spur = 1'b0;
        repeat (3) step();
        chk("post_reset_idle", dbg_state, IDLE);

        // Short random run after reset
        if_rate = 40; dm_rate = 40; drop_rate = 2; spur_rate = 3;
        repeat (300) step();
        set_quiet();
        repeat (40) step();
        chk("queues_drained", mem_q.size() + if_q.size() + dm_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
